// File: rtl/chunk_assembler.sv
// chunk_assembler: reassembles LSB-first chunks into words, double-buffered so
// one chunk per cycle is accepted while the output port drains.
module chunk_assembler #(
    parameter int CHUNK_SIZE_BITS = 4,
    parameter int NUM_CHUNKS      = 8,
    parameter int COUNT_BITS      = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    input  logic [CHUNK_SIZE_BITS-1:0]            in_bits,
    output logic                                  in_ready,
    output logic                                  out_valid,
    output logic [NUM_CHUNKS*CHUNK_SIZE_BITS-1:0] out_word,
    input  logic                                  out_ready,
    output logic                                  overrun,
    output logic [COUNT_BITS-1:0]                 word_count
);
    localparam int DATA_SIZE_BITS = NUM_CHUNKS * CHUNK_SIZE_BITS;
    localparam int IDX_W = $clog2(NUM_CHUNKS);

    logic [IDX_W-1:0]          idx;
    logic [DATA_SIZE_BITS-1:0] asm_q, asm_next;
    logic                      asm_full, accept, last, hold_free, load;

    assign in_ready  = reset && !asm_full;
    assign accept    = in_valid && in_ready;
    assign last      = accept && (idx == IDX_W'(NUM_CHUNKS - 1));
    assign hold_free = !out_valid || out_ready;
    assign load      = hold_free && (asm_full || last);

    always_comb begin
        asm_next = asm_q;
        if (accept) asm_next[idx*CHUNK_SIZE_BITS +: CHUNK_SIZE_BITS] = in_bits;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx        <= '0;
            asm_q      <= '0;
            asm_full   <= 1'b0;
            out_valid  <= 1'b0;
            out_word   <= '0;
            overrun    <= 1'b0;
            word_count <= '0;
        end else begin
            if (accept) idx <= idx + IDX_W'(1);
            asm_q     <= asm_next;
            // A completed word parks in the assembly register until the holding register frees up
            asm_full  <= asm_full ? !hold_free : (last && !hold_free);
            if (load) out_word <= asm_full ? asm_q : asm_next;
            out_valid <= load || (out_valid && !out_ready);
            if (out_valid && out_ready) word_count <= word_count + COUNT_BITS'(1);
            if (in_valid && !in_ready) overrun <= 1'b1;
        end
    end
endmodule

// File: doc/chunk_assembler.md
Name: chunk_assembler

Overview:
- Downstream stage of the chunk serializer. Collects fixed-width chunks (LSB chunk first) and reassembles them into full data words.
- Presents each completed word on a valid/ready output port.
- Input side has a ready signal, but the upstream serializer ignores backpressure. The block therefore double-buffers (one assembly register plus one holding register) so it accepts one chunk per cycle with no gaps while downstream drains.
- Lost chunks set a sticky overrun flag.

Parameters:
- CHUNK_SIZE_BITS, 4, width of one input chunk.
- NUM_CHUNKS, 8, chunks per word (power of two, >=2).
- DATA_SIZE_BITS, NUM_CHUNKS*CHUNK_SIZE_BITS, output word width (derived, not overridable).
- COUNT_BITS, 8, width of the completed-word counter.

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- reset  in  1  synchronous, active-low reset. Low at a rising clk edge resets the block.
- in_valid  in  1  chunk present on in_bits (driven by upstream have_output).
- in_bits  in  CHUNK_SIZE_BITS  chunk data.
- in_ready  out  1  block can accept a chunk this cycle.
- out_valid  out  1  out_word holds a completed word.
- out_word  out  DATA_SIZE_BITS  assembled word.
- out_ready  in  1  downstream accepts out_word this cycle.
- overrun  out  1  sticky: a chunk arrived while in_ready=0 and was dropped.
- word_count  out  COUNT_BITS  number of words handed off (out_valid&&out_ready), wraps modulo 2^COUNT_BITS.

Behaviour:
- Reset (reset=0 at edge):
  - out_valid=0, out_word=0, overrun=0, word_count=0.
  - Fill index=0, assembly register cleared, asm_full=0.
  - in_ready=0 while reset is low (in_ready = reset && !asm_full).
  - Reset mid-word discards the partial word; reset with a word held discards it.
- Accept:
  - A chunk is accepted when in_valid && in_ready.
  - It is written to assembly bits [idx*CHUNK_SIZE_BITS +: CHUNK_SIZE_BITS]. The first accepted chunk is the least significant.
  - idx increments and wraps from NUM_CHUNKS-1 to 0.
- Hold free: hold_free = !out_valid || out_ready.
- Completion (chunk accepted at idx=NUM_CHUNKS-1):
  - If hold_free: the complete word, including the chunk just accepted, loads into out_word on that same edge and out_valid=1. Latency: out_valid rises on the edge that accepts the last chunk. No bubble; the next chunk may be accepted the following cycle.
  - If !hold_free: the word stays in the assembly register and asm_full=1, so in_ready=0.
- Draining asm_full:
  - On any edge with asm_full && hold_free, the assembly word moves to out_word, out_valid=1, asm_full=0, and idx stays 0.
  - in_ready returns to 1 the next cycle.
- Output handshake:
  - On out_valid && out_ready with no new word loading, out_valid=0. out_word holds its last value.
  - Handshake and a new load on the same edge: out_valid stays 1, the new word replaces the old, and word_count increments once.
  - out_word and out_valid are stable while out_valid && !out_ready.
- Overrun:
  - in_valid && !in_ready while reset=1 drops the chunk and sets overrun=1.
  - overrun clears only on reset. idx and assembly contents are unaffected by the dropped chunk.
- word_count: increments by 1 per output handshake, wraps from 2^COUNT_BITS-1 to 0.
- No partial-word flush. A word that never completes stays pending until more chunks arrive or reset.
- All outputs are registered except in_ready, which is a function of registered state and reset only, with no combinational path from in_valid.

Test Plan:
- Release reset, out_ready=1, drive 8 consecutive chunks 4,3,2,1,d,c,b,a -> out_valid=1 on the edge accepting chunk a, out_word=32'habcd1234, one cycle later out_valid=0, word_count=1, overrun=0.
- Same 8 chunks with in_valid gaps of 1-3 cycles -> identical out_word=32'habcd1234, out_valid rises only on the edge accepting the 8th chunk.
- out_ready=0, 16 back-to-back chunks 0..f then one more chunk -> after chunk 8, out_word=32'h76543210 held. After chunk 16, in_ready=0 and the 17th chunk is dropped, overrun=1. Then out_ready=1 -> 32'h76543210 then 32'hfedcba98 handed off in consecutive cycles, word_count=2, in_ready=1.
- Word held with out_ready=1 on the same edge the 8th chunk of the next word is accepted -> out_valid stays 1, out_word switches to the new word, word_count increments by exactly 1.
- Reset pulsed low for one cycle after 5 chunks -> partial word discarded; the next 8 chunks 1..8 give out_word=32'h87654321, overrun=0, word_count=1.
- 257 words streamed with out_ready=1 -> word_count reads 0 after word 256 and 1 after word 257; no overrun.
